// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
//   Shared constants for the fetch stage: address width, default cache line
//   size, reset/exception vectors, FSM state encodings and a saturating
//   counter helper.
package fetch_ctrl_pkg;

  localparam int          FETCH_ADDR_SIZE  = 32;
  localparam int          FETCH_LINE_BYTES = 16;
  localparam logic [31:0] FETCH_RESET_PC   = 32'h0000_1000;
  localparam logic [31:0] FETCH_EXC_VECTOR = 32'h0000_2000;

  // Fetch FSM state encodings
  localparam logic [1:0] FETCH_RUN       = 2'd0;
  localparam logic [1:0] FETCH_MISS_REQ  = 2'd1;
  localparam logic [1:0] FETCH_MISS_WAIT = 2'd2;
  localparam logic [1:0] FETCH_FILL      = 2'd3;

  // Increment that sticks at the ceiling instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] value,
                                          input logic [15:0] ceiling);
    return (value >= ceiling) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc_sel.sv
// fetch_pc_sel
//   Combinational next-PC selector for the fetch stage.
//   Priority: exception > jump > branch > sequential advance > hold.
//   Redirect targets are forced word aligned (bits [1:0] cleared).
// Ports:
//   is_exception, is_jump, is_branch : redirect requests
//   pc_jump, pc_branch               : redirect targets
//   pc                               : current fetch PC
//   advance                          : step to pc+4 when no redirect
//   next_pc                          : PC to load at the next edge
module fetch_pc_sel
  import fetch_ctrl_pkg::*;
#(
  parameter int                   ADDR_SIZE  = FETCH_ADDR_SIZE,
  parameter logic [ADDR_SIZE-1:0] EXC_VECTOR = ADDR_SIZE'(FETCH_EXC_VECTOR)
) (
  input  logic                 is_exception,
  input  logic                 is_jump,
  input  logic                 is_branch,
  input  logic [ADDR_SIZE-1:0] pc_jump,
  input  logic [ADDR_SIZE-1:0] pc_branch,
  input  logic [ADDR_SIZE-1:0] pc,
  input  logic                 advance,
  output logic [ADDR_SIZE-1:0] next_pc
);

  localparam logic [ADDR_SIZE-1:0] WORD_MASK = ~ADDR_SIZE'(3);

  always_comb begin
    next_pc = pc;
    if (is_exception) begin
      next_pc = EXC_VECTOR;
    end else if (is_jump) begin
      next_pc = pc_jump & WORD_MASK;
    end else if (is_branch) begin
      next_pc = pc_branch & WORD_MASK;
    end else if (advance) begin
      // Wraps modulo 2^ADDR_SIZE
      next_pc = pc + ADDR_SIZE'(4);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Fetch-stage sequencer. Owns the PC, looks it up in the I-cache and, on a
//   miss, runs one refill transaction (request, wait, fill) before resuming.
//   Redirects (exception/jump/branch) always update the PC, in any state.
// Ports:
//   clk, reset (async, active-low)
//   is_exception, is_jump, is_branch, pc_jump, pc_branch : redirect inputs
//   stall_in    : downstream not accepting this cycle
//   ic_hit      : combinational cache hit for ic_addr
//   ic_addr     : lookup address (= pc)
//   ic_fill     : one-cycle write strobe for the returned line at mem_addr
//   mem_req, mem_addr, mem_ack, mem_valid : refill memory port
//   pc          : current fetch PC
//   fetch_valid : instruction at pc is valid and accepted this cycle
//   busy        : a refill is in progress
//   miss_cnt    : saturating count of misses started
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                   ADDR_SIZE    = FETCH_ADDR_SIZE,
  parameter logic [ADDR_SIZE-1:0] RESET_PC     = ADDR_SIZE'(FETCH_RESET_PC),
  parameter logic [ADDR_SIZE-1:0] EXC_VECTOR   = ADDR_SIZE'(FETCH_EXC_VECTOR),
  parameter int                   LINE_BYTES   = FETCH_LINE_BYTES,
  // Ceiling of miss_cnt; 16'hFFFF in normal use.
  parameter logic [15:0]          MISS_CNT_SAT = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 is_exception,
  input  logic                 is_jump,
  input  logic                 is_branch,
  input  logic [ADDR_SIZE-1:0] pc_jump,
  input  logic [ADDR_SIZE-1:0] pc_branch,
  input  logic                 stall_in,
  input  logic                 ic_hit,
  output logic [ADDR_SIZE-1:0] ic_addr,
  output logic                 ic_fill,
  output logic                 mem_req,
  output logic [ADDR_SIZE-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic                 mem_valid,
  output logic [ADDR_SIZE-1:0] pc,
  output logic                 fetch_valid,
  output logic                 busy,
  output logic [15:0]          miss_cnt
);

  localparam logic [ADDR_SIZE-1:0] LINE_MASK = ~ADDR_SIZE'(LINE_BYTES - 1);

  logic [1:0]           state_reg, state_next;
  logic [ADDR_SIZE-1:0] pc_reg, pc_next;
  logic [ADDR_SIZE-1:0] miss_addr_reg;
  logic [15:0]          miss_cnt_reg;

  logic redirect;
  logic in_run;
  logic hit_accept;
  logic miss_start;

  assign redirect   = is_exception | is_jump | is_branch;
  assign in_run     = (state_reg == FETCH_RUN);
  // A redirect marks the current lookup as wrong-path, so it neither
  // delivers an instruction nor starts a refill.
  assign hit_accept = in_run && !redirect && ic_hit && !stall_in;
  assign miss_start = in_run && !redirect && !ic_hit;

  fetch_pc_sel #(
    .ADDR_SIZE (ADDR_SIZE),
    .EXC_VECTOR(EXC_VECTOR)
  ) u_pc_sel (
    .is_exception(is_exception),
    .is_jump     (is_jump),
    .is_branch   (is_branch),
    .pc_jump     (pc_jump),
    .pc_branch   (pc_branch),
    .pc          (pc_reg),
    .advance     (hit_accept),
    .next_pc     (pc_next)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH_RUN: begin
        if (miss_start) state_next = FETCH_MISS_REQ;
      end
      FETCH_MISS_REQ: begin
        // Once acked the transaction is committed even if a redirect
        // arrives in the same cycle.
        if (mem_ack)       state_next = FETCH_MISS_WAIT;
        else if (redirect) state_next = FETCH_RUN;
      end
      FETCH_MISS_WAIT: begin
        if (mem_valid) state_next = FETCH_FILL;
      end
      FETCH_FILL: begin
        // The returned line is valid data regardless of redirects.
        state_next = FETCH_RUN;
      end
      default: state_next = FETCH_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= FETCH_RUN;
      pc_reg        <= RESET_PC;
      miss_addr_reg <= '0;
      miss_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (miss_start) begin
        miss_addr_reg <= pc_reg & LINE_MASK;
        miss_cnt_reg  <= sat_inc(miss_cnt_reg, MISS_CNT_SAT);
      end
    end
  end

  assign pc          = pc_reg;
  assign ic_addr     = pc_reg;
  assign mem_addr    = miss_addr_reg;
  assign miss_cnt    = miss_cnt_reg;
  assign mem_req     = (state_reg == FETCH_MISS_REQ);
  assign ic_fill     = (state_reg == FETCH_FILL);
  assign busy        = !in_run;
  assign fetch_valid = reset && hit_accept;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
//   Directed scenarios plus a randomized run against a behavioural model of
//   the fetch sequencer. Inputs change 1ns after the rising edge; outputs are
//   compared on the falling edge.
module tb_fetch_ctrl;

  localparam logic [15:0] SAT      = 16'd300;
  localparam logic [31:0] RST_PC   = 32'h0000_1000;
  localparam logic [31:0] EXC_PC   = 32'h0000_2000;
  localparam int          LINE_B   = 16;
  localparam int          PH_IDLE  = 0;  // fetching normally
  localparam int          PH_REQ   = 1;  // asking memory for a line
  localparam int          PH_WAIT  = 2;  // line requested, not yet returned
  localparam int          PH_FILL  = 3;  // line being written into the cache

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        is_exception, is_jump, is_branch;
  logic [31:0] pc_jump, pc_branch;
  logic        stall_in, ic_hit, mem_ack, mem_valid;
  logic [31:0] ic_addr, mem_addr, pc;
  logic        ic_fill, mem_req, fetch_valid, busy;
  logic [15:0] miss_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_line;
  int          m_phase;
  int          m_cnt;

  fetch_ctrl #(.MISS_CNT_SAT(SAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .is_exception(is_exception),
    .is_jump     (is_jump),
    .is_branch   (is_branch),
    .pc_jump     (pc_jump),
    .pc_branch   (pc_branch),
    .stall_in    (stall_in),
    .ic_hit      (ic_hit),
    .ic_addr     (ic_addr),
    .ic_fill     (ic_fill),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_valid   (mem_valid),
    .pc          (pc),
    .fetch_valid (fetch_valid),
    .busy        (busy),
    .miss_cnt    (miss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_pc    = RST_PC;
    m_line  = 32'h0;
    m_phase = PH_IDLE;
    m_cnt   = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic        redir;
    logic [31:0] old_pc;
    if (!reset) begin
      model_reset();
      return;
    end
    redir  = is_exception | is_jump | is_branch;
    old_pc = m_pc;
    if (is_exception)   m_pc = EXC_PC;
    else if (is_jump)   m_pc = pc_jump - (pc_jump % 4);
    else if (is_branch) m_pc = pc_branch - (pc_branch % 4);
    else if (m_phase == PH_IDLE && ic_hit && !stall_in) m_pc = m_pc + 32'd4;
    case (m_phase)
      PH_IDLE: if (!redir && !ic_hit) begin
        m_line  = old_pc - (old_pc % LINE_B);
        m_cnt   = (m_cnt < int'(SAT)) ? m_cnt + 1 : m_cnt;
        m_phase = PH_REQ;
      end
      PH_REQ: begin
        if (mem_ack)    m_phase = PH_WAIT;
        else if (redir) m_phase = PH_IDLE;
      end
      PH_WAIT: if (mem_valid) m_phase = PH_FILL;
      default: m_phase = PH_IDLE;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_idle();
    is_exception = 1'b0; is_jump = 1'b0; is_branch = 1'b0;
    pc_jump = 32'h0; pc_branch = 32'h0;
    stall_in = 1'b0; ic_hit = 1'b1; mem_ack = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic jump_to(input logic [31:0] target);
    drive_idle();
    is_jump = 1'b1; pc_jump = target;
    tick();
    is_jump = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    model_reset();
    repeat (2) tick();
    @(negedge clk);
    checks++; if (pc !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, RST_PC); end
    checks++; if (ic_addr !== RST_PC) begin errors++; $display("FAIL reset_ic_addr: got %h expected %h", ic_addr, RST_PC); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid: got %b expected 0", fetch_valid); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (ic_fill !== 1'b0) begin errors++; $display("FAIL reset_ic_fill: got %b expected 0", ic_fill); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (miss_cnt !== 16'h0) begin errors++; $display("FAIL reset_miss_cnt: got %h expected 0", miss_cnt); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_miss_addr: got %h expected 0", mem_addr); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_hits();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (pc !== RST_PC + 32'(4 * i)) begin errors++; $display("FAIL hit_pc%0d: got %h expected %h", i, pc, RST_PC + 32'(4 * i)); end
      checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL hit_valid%0d: got %b expected 1", i, fetch_valid); end
      tick();
    end
  endtask

  task automatic test_stall();
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (pc !== 32'h1008) begin errors++; $display("FAIL stall_pc%0d: got %h expected 00001008", i, pc); end
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_valid%0d: got %b expected 0", i, fetch_valid); end
      tick();
    end
    stall_in = 1'b0;
    @(negedge clk);
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL unstall_valid: got %b expected 1", fetch_valid); end
    tick();
    @(negedge clk);
    checks++; if (pc !== 32'h100C) begin errors++; $display("FAIL unstall_pc: got %h expected 0000100c", pc); end
  endtask

  task automatic test_redirects();
    logic [2:0]  flags [4] = '{3'b111, 3'b011, 3'b001, 3'b100};
    logic [31:0] tj    [4] = '{32'h4000, 32'h4003, 32'h4000, 32'h7777};
    logic [31:0] tb    [4] = '{32'h5000, 32'h5000, 32'h5002, 32'h5555};
    logic [31:0] expd  [4] = '{32'h2000, 32'h4000, 32'h5000, 32'h2000};
    for (int i = 0; i < 4; i++) begin
      {is_exception, is_jump, is_branch} = flags[i];
      pc_jump = tj[i]; pc_branch = tb[i];
      @(negedge clk);
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL redir_valid%0d: got %b expected 0", i, fetch_valid); end
      tick();
      drive_idle();
      @(negedge clk);
      checks++; if (pc !== expd[i]) begin errors++; $display("FAIL redir_pc%0d: got %h expected %h", i, pc, expd[i]); end
      tick();
    end
  endtask

  task automatic test_miss();
    jump_to(32'h1234);
    ic_hit = 1'b0;
    @(negedge clk);
    checks++; if (pc !== 32'h1234) begin errors++; $display("FAIL miss_pc: got %h expected 00001234", pc); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL miss_valid: got %b expected 0", fetch_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL miss_run_busy: got %b expected 0", busy); end
    tick();
    mem_valid = 1'b1;  // stray data before the ack must be ignored
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL miss_req1: got %b expected 1", mem_req); end
    checks++; if (mem_addr !== 32'h1230) begin errors++; $display("FAIL miss_addr1: got %h expected 00001230", mem_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL miss_busy: got %b expected 1", busy); end
    checks++; if (miss_cnt !== 16'd1) begin errors++; $display("FAIL miss_cnt: got %0d expected 1", miss_cnt); end
    tick();
    mem_valid = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL miss_req2: got %b expected 1", mem_req); end
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_valid = 1'b1;
      @(negedge clk);
      checks++; if (mem_req !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL miss_wait%0d: got req=%b busy=%b expected req=0 busy=1", i, mem_req, busy); end
      tick();
    end
    mem_valid = 1'b0;
    @(negedge clk);
    checks++; if (ic_fill !== 1'b1) begin errors++; $display("FAIL fill_strobe: got %b expected 1", ic_fill); end
    checks++; if (mem_addr !== 32'h1230) begin errors++; $display("FAIL fill_addr: got %h expected 00001230", mem_addr); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL fill_valid: got %b expected 0", fetch_valid); end
    tick();
    ic_hit = 1'b1;
    @(negedge clk);
    checks++; if (ic_fill !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL resume_state: got fill=%b busy=%b expected 0 0", ic_fill, busy); end
    checks++; if (pc !== 32'h1234 || fetch_valid !== 1'b1) begin errors++; $display("FAIL resume_pc: got %h/%b expected 00001234/1", pc, fetch_valid); end
    tick();
    @(negedge clk);
    checks++; if (pc !== 32'h1238) begin errors++; $display("FAIL resume_next: got %h expected 00001238", pc); end
  endtask

  task automatic test_redirect_miss();
    // Redirect in the request phase before an ack drops the request.
    jump_to(32'h1234);
    ic_hit = 1'b0;
    tick();
    is_branch = 1'b1; pc_branch = 32'h8000;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL drop_req_before: got %b expected 1", mem_req); end
    tick();
    drive_idle();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL drop_state: got busy=%b req=%b expected 0 0", busy, mem_req); end
    checks++; if (pc !== 32'h8000 || fetch_valid !== 1'b1) begin errors++; $display("FAIL drop_pc: got %h/%b expected 00008000/1", pc, fetch_valid); end
    checks++; if (miss_cnt !== 16'd2) begin errors++; $display("FAIL drop_cnt: got %0d expected 2", miss_cnt); end
    tick();
    // Redirect while waiting for data: the old line still gets filled.
    jump_to(32'h1234);
    ic_hit = 1'b0;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0; is_branch = 1'b1; pc_branch = 32'h8000;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || fetch_valid !== 1'b0) begin errors++; $display("FAIL wait_redir: got busy=%b valid=%b expected 1 0", busy, fetch_valid); end
    tick();
    is_branch = 1'b0; mem_valid = 1'b1;
    @(negedge clk);
    checks++; if (pc !== 32'h8000 || busy !== 1'b1) begin errors++; $display("FAIL wait_pc: got %h busy=%b expected 00008000 1", pc, busy); end
    tick();
    mem_valid = 1'b0;
    @(negedge clk);
    checks++; if (ic_fill !== 1'b1 || mem_addr !== 32'h1230) begin errors++; $display("FAIL late_fill: got fill=%b addr=%h expected 1 00001230", ic_fill, mem_addr); end
    tick();
    ic_hit = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || pc !== 32'h8000 || fetch_valid !== 1'b1) begin errors++; $display("FAIL late_resume: got busy=%b pc=%h valid=%b expected 0 00008000 1", busy, pc, fetch_valid); end
    checks++; if (miss_cnt !== 16'd3) begin errors++; $display("FAIL late_cnt: got %0d expected 3", miss_cnt); end
    tick();
  endtask

  task automatic test_wrap();
    jump_to(32'hFFFF_FFFC);
    @(negedge clk);
    checks++; if (pc !== 32'hFFFF_FFFC || fetch_valid !== 1'b1) begin errors++; $display("FAIL wrap_before: got %h/%b expected fffffffc/1", pc, fetch_valid); end
    tick();
    @(negedge clk);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_after: got %h expected 00000000", pc); end
    tick();
  endtask

  task automatic test_async_reset();
    jump_to(32'h1234);
    ic_hit = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL areset_pre_req: got %b expected 1", mem_req); end
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL areset_abandon: got req=%b busy=%b expected 0 0", mem_req, busy); end
    checks++; if (pc !== RST_PC || miss_cnt !== 16'h0) begin errors++; $display("FAIL areset_regs: got pc=%h cnt=%0d expected 00001000 0", pc, miss_cnt); end
    tick();
    drive_idle();
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic redir;
    logic e_fv;
    for (int n = 0; n < 600; n++) begin
      is_exception = ($urandom_range(0, 99) < 3);
      is_jump      = ($urandom_range(0, 99) < 5);
      is_branch    = ($urandom_range(0, 99) < 8);
      pc_jump      = $urandom;
      pc_branch    = $urandom;
      stall_in     = ($urandom_range(0, 99) < 20);
      ic_hit       = ($urandom_range(0, 99) < 75);
      mem_ack      = ($urandom_range(0, 99) < 40);
      mem_valid    = ($urandom_range(0, 99) < 40);
      redir = is_exception | is_jump | is_branch;
      e_fv  = (m_phase == PH_IDLE) && !redir && ic_hit && !stall_in;
      @(negedge clk);
      checks++; if (pc !== m_pc || ic_addr !== m_pc) begin errors++; $display("FAIL rand_pc@%0d: got %h/%h expected %h", n, pc, ic_addr, m_pc); end
      checks++; if (fetch_valid !== e_fv) begin errors++; $display("FAIL rand_valid@%0d: got %b expected %b", n, fetch_valid, e_fv); end
      checks++; if (mem_req !== (m_phase == PH_REQ)) begin errors++; $display("FAIL rand_req@%0d: got %b expected %b", n, mem_req, m_phase == PH_REQ); end
      checks++; if (ic_fill !== (m_phase == PH_FILL)) begin errors++; $display("FAIL rand_fill@%0d: got %b expected %b", n, ic_fill, m_phase == PH_FILL); end
      checks++; if (busy !== (m_phase != PH_IDLE)) begin errors++; $display("FAIL rand_busy@%0d: got %b expected %b", n, busy, m_phase != PH_IDLE); end
      checks++; if (miss_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rand_cnt@%0d: got %0d expected %0d", n, miss_cnt, m_cnt); end
      if (m_phase == PH_REQ || m_phase == PH_FILL) begin
        checks++; if (mem_addr !== m_line) begin errors++; $display("FAIL rand_addr@%0d: got %h expected %h", n, mem_addr, m_line); end
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    // Let any outstanding refill finish (bounded).
    drive_idle();
    mem_ack = 1'b1; mem_valid = 1'b1;
    for (int i = 0; i < 8 && m_phase != PH_IDLE; i++) tick();
    drive_idle();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sat_idle: got busy=%b expected 0", busy); end
    // Each miss is abandoned by a branch in the request phase: 2 cycles each.
    for (int i = 0; i < int'(SAT) + 5; i++) begin
      ic_hit = 1'b0;
      tick();
      ic_hit = 1'b1; is_branch = 1'b1; pc_branch = 32'h3000;
      tick();
      is_branch = 1'b0;
    end
    @(negedge clk);
    checks++; if (miss_cnt !== SAT) begin errors++; $display("FAIL sat_cnt: got %0d expected %0d", miss_cnt, SAT); end
    ic_hit = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (miss_cnt !== SAT || mem_req !== 1'b1) begin errors++; $display("FAIL sat_hold: got cnt=%0d req=%b expected %0d 1", miss_cnt, mem_req, SAT); end
    drive_idle();
    tick();
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_hits();
    test_stall();
    test_redirects();
    test_miss();
    test_redirect_miss();
    test_wrap();
    test_async_reset();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
